trdb_inst_pipeline: RTL and testbench
=====================================

# trdb_inst_pipeline

Three-slot retirement pipeline between the hart interface/filter and the packet-priority stage of the trace encoder. Registers each retired instruction together with the filter's `trace_qualified` decision into last/this/next-cycle slots (lc/tc/nc). It then presents the "this cycle" instruction with the qualification-edge, privilege-change and exception-follow-up events that the packet logic needs to choose a packet format. An optional resync counter flags when a periodic synchronisation packet is due.

## Interface
Parameters:
- `XLEN`, 32: instruction address width; from `trdb_pkg`.
- `RESYNC_MAX`, 1024: qualified instructions between resync requests; must be ≥ 2.

Ports:
- `clk_i` in, 1: clock; all state updates on the rising edge.
- `rst_ni` in, 1: reset; asynchronous, active-low.
- `valid_i` in, 1: an instruction retired this cycle.
- `iaddr_i` in, XLEN: address of the retired instruction.
- `priv_lvl_i` in, 2: privilege level of the retired instruction.
- `exception_i` in, 1: the retired instruction trapped.
- `trace_qualified_i` in, 1: filter decision for this instruction.
- `flush_i` in, 1: drain request; inserts an unqualified bubble.
- `stall_i` in, 1: downstream not ready; freezes the pipeline.
- `ready_o` out, 1: input accepted this cycle; equals `~stall_i & ~flush_i`.
- `tc_valid_o` out, 1: tc slot holds an instruction and its successor is known.
- `tc_iaddr_o` out, XLEN: tc address.
- `tc_priv_o` out, 2: tc privilege.
- `tc_first_qualified_o` out, 1: tc is qualified; lc is unqualified or empty.
- `tc_last_qualified_o` out, 1: tc is qualified; nc is unqualified.
- `tc_priv_change_o` out, 1: tc is qualified; lc is valid with a different privilege.
- `tc_after_exception_o` out, 1: tc is qualified; lc trapped.
- `resync_o` out, 1: resync due (see Configuration).
- `resync_ack_i` in, 1: the packet stage emitted the resync packet.

## Operation
- Each slot holds {v, q, iaddr, priv, exc}. Reset clears all fields of every slot to 0.
- Advance condition `adv = ~stall_i & (flush_i | valid_i)`. On `adv`, lc←tc, tc←nc, and nc←new entry.
  - With `flush_i`, the new entry is {v=1, q=0, iaddr=0, priv=0, exc=0}.
  - Otherwise the new entry is the input fields.
- `flush_i` takes precedence over `valid_i`; a coincident `valid_i` is not accepted (`ready_o`=0) and upstream must hold it.
- When stalled, all slots hold and all outputs stay stable.
- `tc_valid_o = tc.v & nc.v`. Every event output is gated by `tc_valid_o`. An empty lc counts as unqualified, non-trapping, with no privilege change.
- A single qualified instruction surrounded by unqualified ones asserts both first and last qualified together.

## Timing
- All outputs are combinational from slot registers only; no input-to-output combinational path except `ready_o`.
- Latency: an instruction accepted at edge k is in nc after k and in tc after the next advance.
  - `tc_valid_o` for it rises in the cycle following that second accepted entry.
- Pipeline fill: after reset, `tc_valid_o` is 0 until two advances have occurred.
- All outputs are 0 from reset assertion, including mid-operation reset. `ready_o` follows its equation.
- Each tc instruction is presented for exactly one advancing cycle, plus any stalled cycles.

## Configuration
- `TRDB_RESYNC_EN` defined:
  - A counter of width `$clog2(RESYNC_MAX+1)` increments on each advance where `tc_valid_o & tc.q` holds, and saturates at `RESYNC_MAX`.
  - `resync_o = (cnt == RESYNC_MAX)`, held until acknowledged.
  - `resync_ack_i` clears the counter to 0; this overrides an increment in the same cycle.
  - An advance with `tc_first_qualified_o` set loads the counter with 1.
- `TRDB_RESYNC_EN` undefined: no counter is instantiated, `resync_o` is tied to 0, and `resync_ack_i` is ignored.

## Test plan
- Reset then 3 valid qualified instrs at 0x100/0x104/0x108 → `tc_valid_o` first high with `tc_iaddr_o`=0x100 and first_qualified=1. On the next advance, 0x104 is presented with no events.
- Qualified 0x200, then unqualified 0x204 → at tc=0x200, last_qualified=1 (and first_qualified=1 if preceded by unqualified).
- Qualified 0x300, then `flush_i` with `valid_i`=1 → `ready_o`=0; tc=0x300 with last_qualified=1; the held `valid_i` is accepted after flush drops.
- lc priv=3 trapping (exc=1), tc qualified priv=0 → `tc_priv_change_o`=1 and `tc_after_exception_o`=1. `stall_i` held 4 cycles leaves every output unchanged.
- `TRDB_RESYNC_EN`, `RESYNC_MAX`=4: 5 consecutive qualified advances → `resync_o` rises after the 4th and stays high. `resync_ack_i` pulse → `resync_o`=0 next cycle and counter=0.
- Assert `rst_ni` low mid-stream with `tc_valid_o`=1 → all outputs 0 immediately (async). After release, a refill is needed before `tc_valid_o`.

Source files
------------

// File: rtl/trdb_inst_pipeline.sv
// Three-slot (lc/tc/nc) retirement pipeline feeding trace packet selection.
// Optional periodic resync counter enabled by defining TRDB_RESYNC_EN.
module trdb_inst_pipeline #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned RESYNC_MAX = 1024
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   input  logic [XLEN-1:0] iaddr_i,
   input  logic [1:0]      priv_lvl_i,
   input  logic            exception_i,
   input  logic            trace_qualified_i,
   input  logic            flush_i,
   input  logic            stall_i,
   output logic            ready_o,
   output logic            tc_valid_o,
   output logic [XLEN-1:0] tc_iaddr_o,
   output logic [1:0]      tc_priv_o,
   output logic            tc_first_qualified_o,
   output logic            tc_last_qualified_o,
   output logic            tc_priv_change_o,
   output logic            tc_after_exception_o,
   output logic            resync_o,
   input  logic            resync_ack_i
);

   typedef struct packed {
      logic            v;
      logic            q;
      logic [XLEN-1:0] iaddr;
      logic [1:0]      priv;
      logic            exc;
   } slot_t;

   slot_t r_lc;
   slot_t r_tc;
   slot_t r_nc;
   slot_t w_new;

   logic w_adv;
   logic w_tc_valid;
   logic w_tc_qual;
   logic w_lc_qual;
   logic w_first;
   logic w_last;
   logic w_priv_change;
   logic w_after_exc;

   assign w_adv   = ~stall_i & (flush_i | valid_i);
   assign ready_o = ~stall_i & ~flush_i;

   // A flush injects a valid but unqualified bubble so the last real entry drains.
   always_comb begin
      w_new   = '0;
      w_new.v = 1'b1;
      if (!flush_i) begin
         w_new.q     = trace_qualified_i;
         w_new.iaddr = iaddr_i;
         w_new.priv  = priv_lvl_i;
         w_new.exc   = exception_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lc <= '0;
         r_tc <= '0;
         r_nc <= '0;
      end else if (w_adv) begin
         r_lc <= r_tc;
         r_tc <= r_nc;
         r_nc <= w_new;
      end
   end

   assign w_tc_valid    = r_tc.v & r_nc.v;
   assign w_tc_qual     = w_tc_valid & r_tc.q;
   assign w_lc_qual     = r_lc.v & r_lc.q;
   assign w_first       = w_tc_qual & ~w_lc_qual;
   assign w_last        = w_tc_qual & ~r_nc.q;
   assign w_priv_change = w_tc_qual & r_lc.v & (r_lc.priv != r_tc.priv);
   assign w_after_exc   = w_tc_qual & r_lc.v & r_lc.exc;

   assign tc_valid_o           = w_tc_valid;
   assign tc_iaddr_o           = r_tc.iaddr;
   assign tc_priv_o            = r_tc.priv;
   assign tc_first_qualified_o = w_first;
   assign tc_last_qualified_o  = w_last;
   assign tc_priv_change_o     = w_priv_change;
   assign tc_after_exception_o = w_after_exc;

`ifdef TRDB_RESYNC_EN
   localparam int unsigned CNT_W = $clog2(RESYNC_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESYNC_MAX);

   logic [CNT_W-1:0] r_cnt;

   // Ack wins over everything; a fresh qualified run restarts the count at 1.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (resync_ack_i) begin
         r_cnt <= '0;
      end else if (w_adv && w_first) begin
         r_cnt <= CNT_W'(1);
      end else if (w_adv && w_tc_qual && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign resync_o = (r_cnt == CNT_MAX);
`else
   localparam int unsigned unused_resync_max = RESYNC_MAX;
   logic w_unused_ack;

   assign w_unused_ack = resync_ack_i;
   assign resync_o     = 1'b0;
`endif

endmodule

// File: tb/tb_trdb_inst_pipeline.sv
// Directed self-checking bench for trdb_inst_pipeline (resync checks follow TRDB_RESYNC_EN).
module tb_trdb_inst_pipeline;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] iaddr_i = '0;
   logic [1:0]  priv_lvl_i = '0;
   logic        exception_i = 1'b0;
   logic        trace_qualified_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        resync_ack_i = 1'b0;
   logic        ready_o;
   logic        tc_valid_o;
   logic [31:0] tc_iaddr_o;
   logic [1:0]  tc_priv_o;
   logic        tc_first_qualified_o;
   logic        tc_last_qualified_o;
   logic        tc_priv_change_o;
   logic        tc_after_exception_o;
   logic        resync_o;

   logic [4:0]  ev;
   int          n_pass = 0;
   int          n_total = 0;

   assign ev = {tc_valid_o, tc_first_qualified_o, tc_last_qualified_o,
                tc_priv_change_o, tc_after_exception_o};

   trdb_inst_pipeline #(.XLEN(32), .RESYNC_MAX(4)) dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .valid_i              (valid_i),
      .iaddr_i              (iaddr_i),
      .priv_lvl_i           (priv_lvl_i),
      .exception_i          (exception_i),
      .trace_qualified_i    (trace_qualified_i),
      .flush_i              (flush_i),
      .stall_i              (stall_i),
      .ready_o              (ready_o),
      .tc_valid_o           (tc_valid_o),
      .tc_iaddr_o           (tc_iaddr_o),
      .tc_priv_o            (tc_priv_o),
      .tc_first_qualified_o (tc_first_qualified_o),
      .tc_last_qualified_o  (tc_last_qualified_o),
      .tc_priv_change_o     (tc_priv_change_o),
      .tc_after_exception_o (tc_after_exception_o),
      .resync_o             (resync_o),
      .resync_ack_i         (resync_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      rst_ni = 1'b1;
   endtask

   // Present one instruction for a single edge, then return inputs to idle.
   task automatic push(input logic [31:0] a, input logic q, input logic [1:0] p, input logic e);
      valid_i = 1'b1; iaddr_i = a; trace_qualified_i = q; priv_lvl_i = p; exception_i = e;
      @(posedge clk_i); #1;
      valid_i = 1'b0; iaddr_i = '0; trace_qualified_i = 1'b0; priv_lvl_i = '0; exception_i = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_total++;
      if ({ev, tc_iaddr_o, tc_priv_o, resync_o} !== '0) $display("FAIL reset_outs: got ev=%b addr=%h priv=%0d rs=%b required all 0", ev, tc_iaddr_o, tc_priv_o, resync_o);
      else n_pass++;
      n_total++;
      if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b required 1", ready_o);
      else n_pass++;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_fill();
      do_reset();
      push(32'h100, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (tc_valid_o !== 1'b0) $display("FAIL fill_one: got tc_valid=%b required 0", tc_valid_o);
      else n_pass++;
      push(32'h104, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (ev !== 5'b11000 || tc_iaddr_o !== 32'h100) $display("FAIL fill_first: got ev=%b addr=%h required ev=11000 addr=100", ev, tc_iaddr_o);
      else n_pass++;
      push(32'h108, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (ev !== 5'b10000 || tc_iaddr_o !== 32'h104) $display("FAIL fill_mid: got ev=%b addr=%h required ev=10000 addr=104", ev, tc_iaddr_o);
      else n_pass++;
      $display("test_fill done");
   endtask

   task automatic test_last_qualified();
      do_reset();
      push(32'h1fc, 1'b0, 2'd0, 1'b0);
      push(32'h200, 1'b1, 2'd0, 1'b0);
      push(32'h204, 1'b0, 2'd0, 1'b0);
      n_total++;
      if (ev !== 5'b11100 || tc_iaddr_o !== 32'h200) $display("FAIL lastq_single: got ev=%b addr=%h required ev=11100 addr=200", ev, tc_iaddr_o);
      else n_pass++;
      push(32'h208, 1'b0, 2'd0, 1'b0);
      n_total++;
      if (ev !== 5'b10000 || tc_iaddr_o !== 32'h204) $display("FAIL lastq_unqual: got ev=%b addr=%h required ev=10000 addr=204", ev, tc_iaddr_o);
      else n_pass++;
      $display("test_last_qualified done");
   endtask

   task automatic test_flush();
      do_reset();
      push(32'h2fc, 1'b1, 2'd0, 1'b0);
      push(32'h300, 1'b1, 2'd0, 1'b0);
      valid_i = 1'b1; iaddr_i = 32'h304; trace_qualified_i = 1'b1; flush_i = 1'b1;
      #1;
      n_total++;
      if (ready_o !== 1'b0) $display("FAIL flush_ready: got %b required 0", ready_o);
      else n_pass++;
      @(posedge clk_i); #1;
      n_total++;
      if (ev !== 5'b10100 || tc_iaddr_o !== 32'h300) $display("FAIL flush_last: got ev=%b addr=%h required ev=10100 addr=300", ev, tc_iaddr_o);
      else n_pass++;
      flush_i = 1'b0;
      #1;
      n_total++;
      if (ready_o !== 1'b1) $display("FAIL flush_release_ready: got %b required 1", ready_o);
      else n_pass++;
      @(posedge clk_i); #1;
      valid_i = 1'b0; iaddr_i = '0; trace_qualified_i = 1'b0;
      n_total++;
      if (ev !== 5'b10000 || tc_iaddr_o !== 32'h0) $display("FAIL flush_bubble: got ev=%b addr=%h required ev=10000 addr=0", ev, tc_iaddr_o);
      else n_pass++;
      push(32'h308, 1'b0, 2'd0, 1'b0);
      n_total++;
      if (ev !== 5'b11100 || tc_iaddr_o !== 32'h304) $display("FAIL flush_held: got ev=%b addr=%h required ev=11100 addr=304", ev, tc_iaddr_o);
      else n_pass++;
      $display("test_flush done");
   endtask

   task automatic test_priv_exc_stall();
      do_reset();
      push(32'h400, 1'b0, 2'd3, 1'b1);
      push(32'h500, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (ev !== 5'b10000 || tc_priv_o !== 2'd3) $display("FAIL priv_trap_tc: got ev=%b priv=%0d required ev=10000 priv=3", ev, tc_priv_o);
      else n_pass++;
      push(32'h504, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (ev !== 5'b11011 || tc_iaddr_o !== 32'h500 || tc_priv_o !== 2'd0) $display("FAIL priv_exc: got ev=%b addr=%h priv=%0d required ev=11011 addr=500 priv=0", ev, tc_iaddr_o, tc_priv_o);
      else n_pass++;
      valid_i = 1'b1; iaddr_i = 32'h508; trace_qualified_i = 1'b1; stall_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i); #1;
         n_total++;
         if (ev !== 5'b11011 || tc_iaddr_o !== 32'h500 || ready_o !== 1'b0) $display("FAIL stall_hold%0d: got ev=%b addr=%h ready=%b required ev=11011 addr=500 ready=0", i, ev, tc_iaddr_o, ready_o);
         else n_pass++;
      end
      stall_i = 1'b0;
      @(posedge clk_i); #1;
      valid_i = 1'b0; iaddr_i = '0; trace_qualified_i = 1'b0;
      n_total++;
      if (ev !== 5'b10000 || tc_iaddr_o !== 32'h504) $display("FAIL stall_release: got ev=%b addr=%h required ev=10000 addr=504", ev, tc_iaddr_o);
      else n_pass++;
      $display("test_priv_exc_stall done");
   endtask

   task automatic test_resync();
      do_reset();
      push(32'h600, 1'b1, 2'd0, 1'b0);
      push(32'h604, 1'b1, 2'd0, 1'b0);
`ifdef TRDB_RESYNC_EN
      push(32'h608, 1'b1, 2'd0, 1'b0);
      push(32'h60c, 1'b1, 2'd0, 1'b0);
      push(32'h610, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (resync_o !== 1'b0) $display("FAIL resync_early: got %b required 0 after 3 qualified advances", resync_o);
      else n_pass++;
      push(32'h614, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (resync_o !== 1'b1) $display("FAIL resync_rise: got %b required 1 after 4 qualified advances", resync_o);
      else n_pass++;
      push(32'h618, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (resync_o !== 1'b1) $display("FAIL resync_hold: got %b required 1", resync_o);
      else n_pass++;
      resync_ack_i = 1'b1;
      @(posedge clk_i); #1;
      resync_ack_i = 1'b0;
      n_total++;
      if (resync_o !== 1'b0) $display("FAIL resync_ack: got %b required 0", resync_o);
      else n_pass++;
      push(32'h61c, 1'b1, 2'd0, 1'b0);
      push(32'h620, 1'b1, 2'd0, 1'b0);
      push(32'h624, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (resync_o !== 1'b0) $display("FAIL resync_recount: got %b required 0 with count 3", resync_o);
      else n_pass++;
`else
      for (int i = 0; i < 6; i++) push(32'h608 + 32'(4 * i), 1'b1, 2'd0, 1'b0);
      n_total++;
      if (resync_o !== 1'b0) $display("FAIL resync_disabled: got %b required 0", resync_o);
      else n_pass++;
`endif
      $display("test_resync done");
   endtask

   task automatic test_async_reset();
      do_reset();
      push(32'h700, 1'b1, 2'd1, 1'b0);
      push(32'h704, 1'b1, 2'd1, 1'b0);
      n_total++;
      if (tc_valid_o !== 1'b1) $display("FAIL arst_pre: got tc_valid=%b required 1", tc_valid_o);
      else n_pass++;
      #2;
      rst_ni = 1'b0;
      #1;
      n_total++;
      if ({ev, tc_iaddr_o, tc_priv_o, resync_o} !== '0) $display("FAIL arst_outs: got ev=%b addr=%h priv=%0d rs=%b required all 0", ev, tc_iaddr_o, tc_priv_o, resync_o);
      else n_pass++;
      #1;
      rst_ni = 1'b1;
      push(32'h708, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (tc_valid_o !== 1'b0) $display("FAIL arst_refill: got tc_valid=%b required 0", tc_valid_o);
      else n_pass++;
      push(32'h70c, 1'b1, 2'd0, 1'b0);
      n_total++;
      if (ev !== 5'b11000 || tc_iaddr_o !== 32'h708) $display("FAIL arst_refilled: got ev=%b addr=%h required ev=11000 addr=708", ev, tc_iaddr_o);
      else n_pass++;
      $display("test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_fill();
      test_last_qualified();
      test_flush();
      test_priv_exc_stall();
      test_resync();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
